// File: rtl/lcd_hex_display_if.sv
// lcd_hex_display_if: request/status handshake and LCD bus of lcd_hex_display
interface lcd_hex_display_if;
    logic start;
    logic [127:0] value;
    logic busy;
    logic done;
    logic lcd_rw;
    logic lcd_e;
    logic lcd_rs;
    logic [7:0] data;
    modport master (output start, value, input busy, done, lcd_rw, lcd_e, lcd_rs, data);
    modport slave (input start, value, output busy, done, lcd_rw, lcd_e, lcd_rs, data);
endinterface

// File: rtl/lcd_hex_display.sv
// lcd_hex_display: HD44780 8-bit init plus 128-bit value printed as 32 lowercase hex chars
module lcd_hex_display #(
    parameter int POWERUP_CYCLES = 750000,
    parameter int E_PULSE_CYCLES = 12,
    parameter int CMD_WAIT_CYCLES = 2500,
    parameter int CLEAR_WAIT_CYCLES = 100000
) (
    input logic clk,
    input logic rst_n,
    lcd_hex_display_if.slave bus
);
    localparam int MAX_AB = POWERUP_CYCLES > E_PULSE_CYCLES ? POWERUP_CYCLES : E_PULSE_CYCLES;
    localparam int MAX_CD = CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int MAXC = MAX_AB > MAX_CD ? MAX_AB : MAX_CD;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PWR = CW'(POWERUP_CYCLES);
    localparam logic [CW-1:0] E_M1 = CW'(E_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] CMD_M1 = CW'(CMD_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CLR_M1 = CW'(CLEAR_WAIT_CYCLES - 1);
    typedef enum logic [1:0] {PWRUP, INIT, IDLE, WRITE} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;
    state_t state;
    phase_t phase;
    logic [CW-1:0] cnt;
    logic [5:0] idx;
    logic [5:0] nidx;
    logic [127:0] val;
    logic [4:0] pos;
    logic [3:0] nib;
    logic [7:0] init_cmd;
    logic [8:0] nb;
    logic last;
    logic hold_end;
    assign bus.lcd_rw = 1'b0;
    // nb is {rs, data} of the byte the FSM loads next: index 0 on entry, else idx+1
    always_comb begin
        nidx = (state == INIT || state == WRITE) ? idx + 6'd1 : 6'd0;
        pos = (nidx < 6'd17) ? 5'(nidx - 6'd1) : 5'(nidx - 6'd2);
        nib = 4'(val >> (7'd124 - {pos, 2'b00}));
        init_cmd = nidx[1:0] == 2'd0 ? 8'h38 : nidx[1:0] == 2'd1 ? 8'h0C :
                   nidx[1:0] == 2'd2 ? 8'h06 : 8'h01;
        nb = (state == PWRUP || state == INIT) ? {1'b0, init_cmd} :
             nidx == 6'd0 ? {1'b0, 8'h80} : nidx == 6'd17 ? {1'b0, 8'hC0} :
             {1'b1, nib < 4'd10 ? 8'h30 + 8'(nib) : 8'h57 + 8'(nib)};
        last = (state == INIT) ? idx == 6'd3 : idx == 6'd33;
        hold_end = cnt == ((!bus.lcd_rs && bus.data == 8'h01) ? CLR_M1 : CMD_M1);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= PWRUP;
            phase <= SETUP;
            cnt <= '0;
            idx <= '0;
            val <= '0;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            bus.lcd_e <= 1'b0;
            bus.lcd_rs <= 1'b0;
            bus.data <= 8'h00;
        end else begin
            bus.done <= 1'b0;
            case (state)
                PWRUP: begin
                    cnt <= (cnt == PWR) ? '0 : cnt + 1'b1;
                    if (cnt == PWR) begin
                        state <= INIT;
                        phase <= SETUP;
                        idx <= '0;
                        {bus.lcd_rs, bus.data} <= nb;
                    end
                end
                IDLE: if (bus.start) begin
                    state <= WRITE;
                    phase <= SETUP;
                    idx <= '0;
                    val <= bus.value;
                    cnt <= '0;
                    bus.busy <= 1'b1;
                    {bus.lcd_rs, bus.data} <= nb;
                end
                default: case (phase)
                    SETUP: begin
                        phase <= PULSE;
                        bus.lcd_e <= 1'b1;
                        cnt <= '0;
                    end
                    PULSE: begin
                        cnt <= (cnt == E_M1) ? '0 : cnt + 1'b1;
                        if (cnt == E_M1) begin
                            phase <= HOLD;
                            bus.lcd_e <= 1'b0;
                        end
                    end
                    default: begin
                        cnt <= hold_end ? '0 : cnt + 1'b1;
                        if (hold_end && last) begin
                            state <= IDLE;
                            bus.busy <= 1'b0;
                            bus.done <= state == WRITE;
                        end else if (hold_end) begin
                            idx <= idx + 6'd1;
                            phase <= SETUP;
                            {bus.lcd_rs, bus.data} <= nb;
                        end
                    end
                endcase
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_hex_display.sv
// tb_lcd_hex_display: directed and random checks of lcd_hex_display against a byte/timing model
module tb_lcd_hex_display;
    localparam int P = 10, E = 2, CMDW = 3, CLRW = 5;
    localparam int B = 1 + E + CMDW, C = 1 + E + CLRW;
    typedef struct {logic rs; logic [7:0] d; int c;} cap_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int ecount = 0, rel_base = 0, tests = 0, fails = 0;
    int stab_bad = 0, rw_bad = 0, wide_bad = 0;
    logic pe = 1'b0, pr = 1'b0, pdone = 1'b0;
    logic [7:0] pd = 8'h00;
    cap_t cap_q[$];
    cap_t exp_q[$];
    int done_q[$];
    lcd_hex_display_if bus();
    lcd_hex_display #(.POWERUP_CYCLES(P), .E_PULSE_CYCLES(E), .CMD_WAIT_CYCLES(CMDW),
                      .CLEAR_WAIT_CYCLES(CLRW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;
    function automatic int cyc_now();
        return ecount - rel_base;
    endfunction
    // each lcd_e rise records the byte and the SETUP cycle just before it
    always @(negedge clk) begin
        if (bus.lcd_e && !pe) cap_q.push_back('{bus.lcd_rs, bus.data, cyc_now() - 1});
        if (bus.lcd_e && (bus.data !== pd || bus.lcd_rs !== pr)) stab_bad <= stab_bad + 1;
        if (bus.lcd_rw !== 1'b0) rw_bad <= rw_bad + 1;
        if (bus.done && pdone) wide_bad <= wide_bad + 1;
        if (bus.done) done_q.push_back(cyc_now());
        pe <= bus.lcd_e;
        pd <= bus.data;
        pr <= bus.lcd_rs;
        pdone <= bus.done;
    end
    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask
    task automatic add_init();
        logic [7:0] cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        for (int j = 0; j < 4; j++) exp_q.push_back('{1'b0, cmds[j], P + j * B});
    endtask
    task automatic add_write(input logic [127:0] v, input int s0);
        string h = $sformatf("%032h", v);
        exp_q.push_back('{1'b0, 8'h80, s0});
        for (int k = 0; k < 16; k++) exp_q.push_back('{1'b1, h[k], s0 + (1 + k) * B});
        exp_q.push_back('{1'b0, 8'hC0, s0 + 17 * B});
        for (int k = 16; k < 32; k++) exp_q.push_back('{1'b1, h[k], s0 + (2 + k) * B});
    endtask
    task automatic cmp_caps(input string tag);
        check({tag, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {cap_q[i].rs, cap_q[i].d, 32'(cap_q[i].c)},
                  {exp_q[i].rs, exp_q[i].d, 32'(exp_q[i].c)});
    endtask
    task automatic wait_done(output int c, input int lim);
        c = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (bus.done) begin
                c = cyc_now();
                break;
            end
        end
    endtask
    task automatic wait_idle(output int c, input int lim);
        c = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                c = cyc_now();
                break;
            end
        end
    endtask
    task automatic release_reset();
        rst_n = 1'b1;
        rel_base = ecount + 1;
        cap_q.delete();
        exp_q.delete();
        done_q.delete();
        add_init();
    endtask
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic do_write(input string tag, input logic [127:0] v, input bit poke);
        int s0, dc, r;
        cap_q.delete();
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.start = 1'b0;
        s0 = cyc_now();
        bus.value = rnd128();
        add_write(v, s0);
        if (poke) begin
            r = $urandom_range(1, 150);
            repeat (r) @(negedge clk);
            bus.start = 1'b1;
            bus.value = ~v;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_done(dc, 300);
        check({tag, "_done_cycle"}, 64'(dc), 64'(s0 + 34 * B));
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
        repeat (2 * B) @(negedge clk);
        cmp_caps(tag);
        check({tag, "_done_count"}, 64'(done_q.size()), 64'(1));
    endtask
    initial begin
        int c, s0, d1, d2;
        logic [127:0] v1, v2;
        bus.start = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        check("rst_lcd_e", 64'(bus.lcd_e), 64'(0));
        check("rst_lcd_rs", 64'(bus.lcd_rs), 64'(0));
        check("rst_lcd_rw", 64'(bus.lcd_rw), 64'(0));
        check("rst_data", 64'(bus.data), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(1));
        check("rst_done", 64'(bus.done), 64'(0));
        release_reset();
        repeat (15) @(negedge clk);
        bus.start = 1'b1;
        bus.value = rnd128();
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(c, 100);
        check("init_busy_fall", 64'(c), 64'(P + 3 * B + C));
        repeat (10) @(negedge clk);
        cmp_caps("init");
        check("init_still_idle", 64'(bus.busy), 64'(0));
        check("init_no_done", 64'(done_q.size()), 64'(0));
        do_write("plain", 128'h00112233445566778899aabbccddeeff, 1'b0);
        do_write("zeros", '0, 1'b0);
        do_write("ones", '1, 1'b0);
        do_write("rand_a", rnd128(), 1'b1);
        do_write("rand_b", rnd128(), 1'b1);
        // abort a write during the PULSE of char 5 (byte index 6)
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = rnd128();
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6 * B + 1) @(negedge clk);
        check("abort_in_pulse", 64'(bus.lcd_e), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_lcd_e", 64'(bus.lcd_e), 64'(0));
        check("abort_data", 64'(bus.data), 64'(0));
        check("abort_lcd_rs", 64'(bus.lcd_rs), 64'(0));
        check("abort_busy", 64'(bus.busy), 64'(1));
        check("abort_done", 64'(bus.done), 64'(0));
        release_reset();
        wait_idle(c, 100);
        check("reinit_busy_fall", 64'(c), 64'(P + 3 * B + C));
        repeat (5) @(negedge clk);
        cmp_caps("reinit");
        check("reinit_no_done", 64'(done_q.size()), 64'(0));
        v1 = rnd128();
        v2 = rnd128();
        cap_q.delete();
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = v1;
        @(negedge clk);
        s0 = cyc_now();
        bus.value = v2;
        add_write(v1, s0);
        add_write(v2, s0 + 34 * B + 1);
        wait_done(d1, 300);
        check("b2b_done1", 64'(d1), 64'(s0 + 34 * B));
        @(negedge clk);
        bus.start = 1'b0;
        bus.value = rnd128();
        wait_done(d2, 300);
        check("b2b_done2", 64'(d2), 64'(s0 + 68 * B + 1));
        repeat (2 * B) @(negedge clk);
        cmp_caps("b2b");
        check("b2b_done_count", 64'(done_q.size()), 64'(2));
        check("rw_always_low", 64'(rw_bad), 64'(0));
        check("data_stable_with_e", 64'(stab_bad), 64'(0));
        check("done_one_cycle", 64'(wide_bad), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
